// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt controller: register offsets,
// FSM state encoding and the Wishbone byte-lane helper.
package timer_irq_pkg;

  localparam logic [1:0] PEND_OFF  = 2'd0;
  localparam logic [1:0] EN_OFF    = 2'd1;
  localparam logic [1:0] CLAIM_OFF = 2'd2;
  localparam logic [1:0] CFG_OFF   = 2'd3;

  localparam logic [31:0] ADR_MAX = 32'h0000_000C;

  localparam int CLAIM_VALID_BIT = 31;
  localparam int CFG_RR_BIT      = 0;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    IN_SVC
  } irq_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/irq_rr_arbiter.sv
// Combinational winner selection over the candidate vector. Fixed mode picks
// the lowest index; round-robin mode searches upward from rr_ptr and wraps.
module irq_rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         cand,
  input  logic [$clog2(N)-1:0] rr_ptr,
  input  logic                 rr_mode,
  output logic [7:0]           gnt_id,
  output logic                 gnt_valid
);

  int         start;
  logic [7:0] hi_id;
  logic       hi_valid;
  logic [7:0] lo_id;

  // Lowest set index at/above start, falling back to the lowest overall (wrap).
  always_comb begin
    start    = rr_mode ? int'(rr_ptr) : 0;
    hi_id    = '0;
    hi_valid = 1'b0;
    lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_id = 8'(i);
        if (i >= start) begin
          hi_id    = 8'(i);
          hi_valid = 1'b1;
        end
      end
    end
    gnt_valid = |cand;
    gnt_id    = hi_valid ? hi_id : lo_id;
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt controller for a bank of timers: edge-captures irq lines into
// PENDING, arbitrates enabled candidates, and runs a claim/complete handshake.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  input  logic [31:0]      wb_adr,
  input  logic [3:0]       wb_sel,
  input  logic [31:0]      wb_dat_ms,
  output logic [31:0]      wb_dat_sm,
  output logic             wb_ack,
  output logic             wb_err
);

  localparam int PTR_W = $clog2(N_IRQ);

  irq_state_e state_q, state_d;

  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] en_q, en_d;
  logic             rr_mode_q, rr_mode_d;
  logic [7:0]       in_svc_id_q, in_svc_id_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             irq_o_q, irq_o_d;
  logic             armed_q, armed_d;

  logic             acc, wr, rd;
  logic [N_IRQ-1:0] lane_mask, wr_bits;
  logic [N_IRQ-1:0] pend_set, claim_clr, cand;
  logic             claim_rd, claim_wr, claim_hit;
  logic [7:0]       gnt_id;
  logic             gnt_valid;
  logic [31:0]      rd_data;

  assign wb_ack    = wb_cyc & wb_stb;
  assign wb_err    = wb_ack & (wb_adr > ADR_MAX);
  assign acc       = wb_ack & ~wb_err;
  assign wr        = acc & wb_we;
  assign rd        = acc & ~wb_we;
  assign claim_rd  = rd & (wb_adr[3:2] == CLAIM_OFF);
  assign claim_wr  = wr & (wb_adr[3:2] == CLAIM_OFF);
  assign lane_mask = N_IRQ'(byte_mask(wb_sel));
  assign wr_bits   = N_IRQ'(wb_dat_ms & byte_mask(wb_sel));
  assign cand      = pend_q & en_q;
  assign irq_o     = irq_o_q;

  // armed_q suppresses capture on the first cycle after reset so a line that
  // is already high when reset lifts needs a fresh 0->1 transition.
  assign pend_set  = irq_i & ~irq_q & {N_IRQ{armed_q}};

  irq_rr_arbiter #(.N(N_IRQ)) u_arb (
    .cand      (cand),
    .rr_ptr    (rr_ptr_q),
    .rr_mode   (rr_mode_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d   = state_q;
    claim_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|cand) state_d = ASSERT;
      end
      ASSERT: begin
        if (claim_rd && gnt_valid) begin
          state_d   = IN_SVC;
          claim_hit = 1'b1;
        end else if (~|cand) begin
          state_d = IDLE;
        end
      end
      IN_SVC: begin
        if (claim_wr && (wb_dat_ms[7:0] == in_svc_id_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) begin
      claim_clr[i] = claim_hit && (gnt_id == 8'(i));
    end
  end

  // A hardware set in the same cycle as a W1C or claim clear wins.
  always_comb begin
    irq_d       = irq_i;
    armed_d     = 1'b1;
    pend_d      = pend_q & ~claim_clr;
    en_d        = en_q;
    rr_mode_d   = rr_mode_q;
    in_svc_id_d = in_svc_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (wr && (wb_adr[3:2] == PEND_OFF)) pend_d = pend_d & ~wr_bits;
    if (wr && (wb_adr[3:2] == EN_OFF))   en_d   = (en_q & ~lane_mask) | wr_bits;
    if (wr && (wb_adr[3:2] == CFG_OFF) && wb_sel[0]) begin
      rr_mode_d = wb_dat_ms[CFG_RR_BIT] & (RR_EN != 0);
    end
    pend_d = pend_d | pend_set;
    if (claim_hit) begin
      in_svc_id_d = gnt_id;
      rr_ptr_d    = (gnt_id == 8'(N_IRQ - 1)) ? '0 : PTR_W'(gnt_id + 8'd1);
    end
    irq_o_d = (state_d == ASSERT);
  end

  always_comb begin
    rd_data = '0;
    unique case (wb_adr[3:2])
      PEND_OFF: rd_data = 32'(pend_q);
      EN_OFF:   rd_data = 32'(en_q);
      CLAIM_OFF: begin
        if (state_q == ASSERT && gnt_valid) begin
          rd_data[CLAIM_VALID_BIT] = 1'b1;
          rd_data[7:0]             = gnt_id;
        end
      end
      CFG_OFF: begin
        rd_data[CFG_RR_BIT] = rr_mode_q;
        rd_data[15:8]       = in_svc_id_q;
      end
      default: rd_data = '0;
    endcase
    wb_dat_sm = rd ? rd_data : 32'h0;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      rr_mode_q   <= 1'b0;
      in_svc_id_q <= '0;
      rr_ptr_q    <= '0;
      irq_o_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      rr_mode_q   <= rr_mode_d;
      in_svc_id_q <= in_svc_id_d;
      rr_ptr_q    <= rr_ptr_d;
      irq_o_q     <= irq_o_d;
      armed_q     <= armed_d;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: claim/complete flow, fixed and
// round-robin arbitration, W1C races, bus errors and mid-service reset.
module tb_timer_irq_ctrl;

  logic        clk;
  logic        rstn_i;
  logic [7:0]  irq_i;
  logic        irq_o;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_ms;
  logic [31:0] wb_dat_sm;
  logic        wb_ack, wb_err;

  logic [31:0] rd_data;
  logic        rd_ack, rd_err;
  int          checks   = 0;
  int          failures = 0;

  timer_irq_ctrl #(.N_IRQ(8), .RR_EN(1)) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .irq_i     (irq_i),
    .irq_o     (irq_o),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_sel    (wb_sel),
    .wb_dat_ms (wb_dat_ms),
    .wb_dat_sm (wb_dat_sm),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called just after a negedge; holds the access for one cycle and returns
  // at the following negedge with the bus idle.
  task automatic wbAccess(input logic we, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [3:0] sel);
    wb_cyc    = 1'b1;
    wb_stb    = 1'b1;
    wb_we     = we;
    wb_adr    = adr;
    wb_dat_ms = wdat;
    wb_sel    = sel;
    #1;
    rd_data = wb_dat_sm;
    rd_ack  = wb_ack;
    rd_err  = wb_err;
    @(negedge clk);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] wdat);
    wbAccess(1'b1, adr, wdat, 4'hF);
  endtask

  task automatic wbRead(input logic [31:0] adr);
    wbAccess(1'b0, adr, 32'h0, 4'hF);
  endtask

  // One-cycle pulse on the selected lines; returns after the capturing edge.
  task automatic applyStimulus(input logic [7:0] pulse);
    irq_i = irq_i | pulse;
    @(negedge clk);
    irq_i = irq_i & ~pulse;
  endtask

  initial begin
    rstn_i    = 1'b0;
    irq_i     = '0;
    wb_cyc    = 1'b0;
    wb_stb    = 1'b0;
    wb_we     = 1'b0;
    wb_adr    = '0;
    wb_sel    = '0;
    wb_dat_ms = '0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);

    checkOutput("rst_irq_o", {31'b0, irq_o}, 32'h0);
    checkOutput("rst_ack_idle", {31'b0, wb_ack}, 32'h0);
    wbRead(32'h0);  checkOutput("rst_pend", rd_data, 32'h0);
    checkOutput("rst_rd_ack", {31'b0, rd_ack}, 32'h1);
    checkOutput("rst_rd_err", {31'b0, rd_err}, 32'h0);
    wbRead(32'h4);  checkOutput("rst_en", rd_data, 32'h0);
    wbRead(32'hC);  checkOutput("rst_cfg", rd_data, 32'h0);
    wbRead(32'h8);  checkOutput("rst_claim", rd_data, 32'h0);

    // Single pulse: latency and claim format
    wbWrite(32'h4, 32'hFF);
    applyStimulus(8'h08);
    checkOutput("t1_irq_o_n1", {31'b0, irq_o}, 32'h0);
    wbRead(32'h0);  checkOutput("t1_pend_n1", rd_data, 32'h08);
    checkOutput("t1_irq_o_n2", {31'b0, irq_o}, 32'h1);
    wbRead(32'h8);  checkOutput("t1_claim", rd_data, 32'h8000_0003);
    checkOutput("t1_irq_o_svc", {31'b0, irq_o}, 32'h0);
    wbRead(32'h0);  checkOutput("t1_pend_clr", rd_data, 32'h0);
    wbRead(32'hC);  checkOutput("t1_cfg_svc", rd_data, 32'h0000_0300);

    // Wrong complete ignored, then the right one
    wbWrite(32'h8, 32'h02);
    applyStimulus(8'h40);
    @(negedge clk);
    checkOutput("t2_irq_o_hold", {31'b0, irq_o}, 32'h0);
    wbRead(32'h0);  checkOutput("t2_pend_insvc", rd_data, 32'h40);
    wbWrite(32'h8, 32'h03);
    @(negedge clk);
    checkOutput("t2_irq_o_next", {31'b0, irq_o}, 32'h1);
    wbRead(32'h8);  checkOutput("t2_claim6", rd_data, 32'h8000_0006);
    wbWrite(32'h8, 32'h06);
    repeat (2) @(negedge clk);
    checkOutput("t2_irq_o_idle", {31'b0, irq_o}, 32'h0);
    wbRead(32'h0);  checkOutput("t2_pend_empty", rd_data, 32'h0);

    // Fixed priority
    applyStimulus(8'h22);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t3_claim1", rd_data, 32'h8000_0001);
    wbWrite(32'h8, 32'h01);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t3_claim5", rd_data, 32'h8000_0005);
    wbWrite(32'h8, 32'h05);

    // Round-robin with wrap
    wbWrite(32'hC, 32'h1);
    wbRead(32'hC);  checkOutput("t4_cfg", rd_data, 32'h0000_0501);
    applyStimulus(8'h40);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t4_claim6", rd_data, 32'h8000_0006);
    applyStimulus(8'h84);
    wbWrite(32'h8, 32'h06);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t4_claim7", rd_data, 32'h8000_0007);
    applyStimulus(8'h01);
    wbWrite(32'h8, 32'h07);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t4_claim0_wrap", rd_data, 32'h8000_0000);
    wbWrite(32'h8, 32'h00);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t4_claim2", rd_data, 32'h8000_0002);
    wbWrite(32'h8, 32'h02);
    wbWrite(32'hC, 32'h0);

    // W1C races and byte lanes
    wbWrite(32'h4, 32'h00);
    applyStimulus(8'h10);
    wbRead(32'h0);  checkOutput("t5_pend_set", rd_data, 32'h10);
    irq_i[4] = 1'b1;
    wbWrite(32'h0, 32'h10);
    irq_i[4] = 1'b0;
    wbRead(32'h0);  checkOutput("t5_set_wins", rd_data, 32'h10);
    wbAccess(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0010);
    wbRead(32'h0);  checkOutput("t5_w1c_lane_off", rd_data, 32'h10);
    wbAccess(1'b1, 32'h0, 32'h10, 4'b0001);
    wbRead(32'h0);  checkOutput("t5_w1c_lane_on", rd_data, 32'h0);
    wbAccess(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b1110);
    wbRead(32'h4);  checkOutput("t5_en_lane_off", rd_data, 32'h0);

    // ENABLE dropped while asserting
    wbWrite(32'h4, 32'hFF);
    applyStimulus(8'h08);
    @(negedge clk);
    checkOutput("t5_assert", {31'b0, irq_o}, 32'h1);
    wbWrite(32'h4, 32'h00);
    @(negedge clk);
    checkOutput("t5_en_drop", {31'b0, irq_o}, 32'h0);
    wbRead(32'h0);  checkOutput("t5_pend_kept", rd_data, 32'h08);

    // Out-of-range accesses
    wbRead(32'h10);
    checkOutput("t6_rd_ack", {31'b0, rd_ack}, 32'h1);
    checkOutput("t6_rd_err", {31'b0, rd_err}, 32'h1);
    wbWrite(32'h10, 32'hFF);
    checkOutput("t6_wr_err", {31'b0, rd_err}, 32'h1);
    wbRead(32'h0);  checkOutput("t6_pend_same", rd_data, 32'h08);
    checkOutput("t6_ok_err", {31'b0, rd_err}, 32'h0);

    // Reset during service with a level held across deassertion
    wbWrite(32'h4, 32'hFF);
    @(negedge clk);
    wbRead(32'h8);  checkOutput("t6_claim3", rd_data, 32'h8000_0003);
    irq_i[2] = 1'b1;
    @(negedge clk);
    rstn_i = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_irq_o", {31'b0, irq_o}, 32'h0);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk);
    wbRead(32'h0);  checkOutput("t6_rst_pend", rd_data, 32'h0);
    wbRead(32'h4);  checkOutput("t6_rst_en", rd_data, 32'h0);
    wbRead(32'hC);  checkOutput("t6_rst_cfg", rd_data, 32'h0);
    checkOutput("t6_rst_irq_o2", {31'b0, irq_o}, 32'h0);
    irq_i[2] = 1'b0;
    @(negedge clk);
    applyStimulus(8'h04);
    wbRead(32'h0);  checkOutput("t6_recapture", rd_data, 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
